// File: rtl/eth_tx_arbiter.sv
// Packet-level weighted round-robin arbiter merging two 64-bit AXI-Stream sources onto
// the Ethernet MAC TX stream. It has programmable weights and per-port packet counters.
module eth_tx_arbiter #(
   parameter int REG_AWIDTH = 14,
   parameter int BASE       = 0,
   parameter int DEFAULT_W0 = 4,
   parameter int DEFAULT_W1 = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  reg_wr_req,
   input  logic [REG_AWIDTH-1:0] reg_wr_addr,
   input  logic [31:0]           reg_wr_data,
   input  logic                  reg_rd_req,
   input  logic [REG_AWIDTH-1:0] reg_rd_addr,
   output logic                  reg_rd_resp,
   output logic [31:0]           reg_rd_data,
   input  logic [63:0]           s0_tdata,
   input  logic [3:0]            s0_tuser,
   input  logic                  s0_tlast,
   input  logic                  s0_tvalid,
   output logic                  s0_tready,
   input  logic [63:0]           s1_tdata,
   input  logic [3:0]            s1_tuser,
   input  logic                  s1_tlast,
   input  logic                  s1_tvalid,
   output logic                  s1_tready,
   output logic [63:0]           m_tdata,
   output logic [3:0]            m_tuser,
   output logic                  m_tlast,
   output logic                  m_tvalid,
   input  logic                  m_tready
);
   typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

   localparam logic [REG_AWIDTH-1:0] ADDR_WEIGHT = REG_AWIDTH'(BASE);
   localparam logic [REG_AWIDTH-1:0] ADDR_CNT0   = REG_AWIDTH'(BASE + 4);
   localparam logic [REG_AWIDTH-1:0] ADDR_CNT1   = REG_AWIDTH'(BASE + 8);
   localparam logic [REG_AWIDTH-1:0] ADDR_CLR    = REG_AWIDTH'(BASE + 12);

   state_t      state_q;
   logic        last_q;
   logic [7:0]  credit_q;
   logic [7:0]  w0_q, w1_q;
   logic [7:0]  eff_w0, eff_w1;
   logic [31:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic        rd_resp_q;
   logic [31:0] rd_data_q;
   logic        rd_hit;
   logic [31:0] rd_mux;
   logic        pref, pref_vld, other_vld, gnt, eop;
   logic        cnt_clr;
   logic        unused_wr_bits;

   assign unused_wr_bits = ^reg_wr_data[31:16];

   // A programmed weight of zero still allows one packet per turn.
   assign eff_w0 = (w0_q == 8'd0) ? 8'd1 : w0_q;
   assign eff_w1 = (w1_q == 8'd0) ? 8'd1 : w1_q;

   assign pref      = (credit_q != 8'd0) ? last_q : ~last_q;
   assign pref_vld  = pref ? s1_tvalid : s0_tvalid;
   assign other_vld = pref ? s0_tvalid : s1_tvalid;
   assign gnt       = pref_vld ? pref : ~pref;
   assign eop       = m_tvalid & m_tready & m_tlast;

   // The mux is combinational so that reset clears the grant, and m_tvalid, at once.
   always_comb begin
      m_tdata   = s0_tdata;
      m_tuser   = s0_tuser;
      m_tlast   = s0_tlast;
      m_tvalid  = 1'b0;
      s0_tready = 1'b0;
      s1_tready = 1'b0;
      case (state_q)
         GRANT0: begin
            m_tvalid  = s0_tvalid;
            s0_tready = m_tready;
         end
         GRANT1: begin
            m_tdata   = s1_tdata;
            m_tuser   = s1_tuser;
            m_tlast   = s1_tlast;
            m_tvalid  = s1_tvalid;
            s1_tready = m_tready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         credit_q <= 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pref_vld | other_vld) begin
                  state_q <= gnt ? GRANT1 : GRANT0;
                  if ((gnt != last_q) || (credit_q == 8'd0))
                     credit_q <= gnt ? eff_w1 : eff_w0;
               end
            end
            GRANT0, GRANT1: begin
               if (eop) begin
                  credit_q <= credit_q - 8'd1;
                  last_q   <= (state_q == GRANT1);
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cnt_clr = reg_wr_req && (reg_wr_addr == ADDR_CLR) && reg_wr_data[0];

   // A clear takes priority over an end-of-packet increment in the same cycle.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (cnt_clr) begin
         cnt0_d = 32'd0;
         cnt1_d = 32'd0;
      end else if (eop) begin
         if (state_q == GRANT0) cnt0_d = cnt0_q + 32'd1;
         if (state_q == GRANT1) cnt1_d = cnt1_q + 32'd1;
      end
   end

   always_comb begin
      rd_hit = 1'b0;
      rd_mux = 32'd0;
      if (reg_rd_req) begin
         case (reg_rd_addr)
            ADDR_WEIGHT: begin rd_hit = 1'b1; rd_mux = {16'd0, w1_q, w0_q}; end
            ADDR_CNT0:   begin rd_hit = 1'b1; rd_mux = cnt0_q; end
            ADDR_CNT1:   begin rd_hit = 1'b1; rd_mux = cnt1_q; end
            ADDR_CLR:    begin rd_hit = 1'b1; rd_mux = 32'd0; end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w0_q      <= 8'(DEFAULT_W0);
         w1_q      <= 8'(DEFAULT_W1);
         cnt0_q    <= 32'd0;
         cnt1_q    <= 32'd0;
         rd_resp_q <= 1'b0;
         rd_data_q <= 32'd0;
      end else begin
         if (reg_wr_req && (reg_wr_addr == ADDR_WEIGHT)) begin
            w0_q <= reg_wr_data[7:0];
            w1_q <= reg_wr_data[15:8];
         end
         cnt0_q    <= cnt0_d;
         cnt1_q    <= cnt1_d;
         rd_resp_q <= rd_hit;
         if (rd_hit) rd_data_q <= rd_mux;
      end
   end

   assign reg_rd_resp = rd_resp_q;
   assign reg_rd_data = rd_data_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter. It runs a register vector table, and it uses a per-port
// scoreboard of expected beats together with the expected grant order.
module tb_eth_tx_arbiter;
   typedef struct packed {logic [63:0] d; logic [3:0] u; logic l;} beat_t;
   typedef struct {logic wr; logic [13:0] addr; logic [31:0] wdata; logic resp; logic [31:0] rdata;} reg_vec_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        reg_wr_req = 1'b0, reg_rd_req = 1'b0;
   logic [13:0] reg_wr_addr = '0, reg_rd_addr = '0;
   logic [31:0] reg_wr_data = '0;
   logic        reg_rd_resp;
   logic [31:0] reg_rd_data;
   logic [63:0] sd0 = '0, sd1 = '0;
   logic [3:0]  su0 = '0, su1 = '0;
   logic        sl0 = 1'b0, sl1 = 1'b0, sv0 = 1'b0, sv1 = 1'b0;
   logic        s0_tready, s1_tready;
   logic [63:0] m_tdata;
   logic [3:0]  m_tuser;
   logic        m_tlast, m_tvalid;
   logic        m_tready = 1'b1;

   always #5 clk = ~clk;

   eth_tx_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .reg_wr_req(reg_wr_req), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
      .reg_rd_req(reg_rd_req), .reg_rd_addr(reg_rd_addr),
      .reg_rd_resp(reg_rd_resp), .reg_rd_data(reg_rd_data),
      .s0_tdata(sd0), .s0_tuser(su0), .s0_tlast(sl0), .s0_tvalid(sv0), .s0_tready(s0_tready),
      .s1_tdata(sd1), .s1_tuser(su1), .s1_tlast(sl1), .s1_tvalid(sv1), .s1_tready(s1_tready),
      .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
      .m_tready(m_tready)
   );

   int          n_cmp = 0, n_err = 0, cyc = 0, pkt_id = 0;
   int          first_fire = -1, last_fire = -1, cur_p = 0;
   bit          in_pkt = 0, rdy_rand = 0, gap_en = 0;
   logic        f0 = 1'b0, f1 = 1'b0;
   logic        samp_resp = 1'b0;
   logic [31:0] samp_data = '0;
   beat_t       src0[$], src1[$], exp0[$], exp1[$];
   int          order[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_pkt(input int p, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d = {4'(p), 12'(pkt_id), 16'(i), $urandom};
         b.u = (i == len - 1) ? 4'($urandom_range(1, 8)) : 4'd8;
         b.l = (i == len - 1);
         if (p == 0) begin src0.push_back(b); exp0.push_back(b); end
         else        begin src1.push_back(b); exp1.push_back(b); end
      end
      pkt_id++;
   endtask

   task automatic sample();
      beat_t e;
      int    p, nf, qs;
      logic  mf;
      @(negedge clk);
      cyc++;
      f0 = sv0 & s0_tready;
      f1 = sv1 & s1_tready;
      mf = m_tvalid & m_tready;
      samp_resp = reg_rd_resp;
      samp_data = reg_rd_data;
      nf = int'(f0) + int'(f1);
      if (mf || nf != 0) chk("src_fire_vs_m_fire", 64'(nf), mf ? 64'd1 : 64'd0);
      if (mf) begin
         p = f1 ? 1 : 0;
         if (in_pkt) chk("no_interleave_port", 64'(p), 64'(cur_p));
         qs = p ? exp1.size() : exp0.size();
         if (qs == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_beat: port%0d beat %0h, expected none queued", p, m_tdata);
         end else begin
            if (p == 1) e = exp1.pop_front(); else e = exp0.pop_front();
            chk("beat_tdata", m_tdata, e.d);
            chk("beat_tuser_tlast", 64'({m_tuser, m_tlast}), 64'({e.u, e.l}));
         end
         in_pkt = !m_tlast;
         cur_p  = p;
         if (m_tlast) order.push_back(p);
         if (first_fire < 0) first_fire = cyc;
         last_fire = cyc;
      end
   endtask

   task automatic drive();
      @(posedge clk);
      #1;
      if (f0) src0.delete(0);
      if (f1) src1.delete(0);
      if (!(sv0 && !f0)) begin
         if (src0.size() > 0 && !(gap_en && $urandom_range(0, 2) == 0)) begin
            sv0 = 1'b1; {sd0, su0, sl0} = src0[0];
         end else sv0 = 1'b0;
      end
      if (!(sv1 && !f1)) begin
         if (src1.size() > 0) begin sv1 = 1'b1; {sd1, su1, sl1} = src1[0]; end
         else sv1 = 1'b0;
      end
      m_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
   endtask

   task automatic cycle();
      sample();
      drive();
   endtask

   task automatic run(input int maxc, input string nm);
      int n = 0;
      while ((src0.size() + src1.size() + exp0.size() + exp1.size()) != 0 || in_pkt) begin
         if (n >= maxc) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: %0d beats pending after %0d cycles", nm, exp0.size() + exp1.size(), maxc);
            return;
         end
         cycle();
         n++;
      end
   endtask

   task automatic reg_write(input logic [13:0] a, input logic [31:0] d);
      reg_wr_req = 1'b1; reg_wr_addr = a; reg_wr_data = d;
      cycle();
      reg_wr_req = 1'b0;
   endtask

   task automatic reg_read(input string nm, input logic [13:0] a, input logic er, input logic [31:0] ed);
      reg_rd_req = 1'b1; reg_rd_addr = a;
      cycle();
      reg_rd_req = 1'b0;
      cycle();
      chk({nm, "_resp"}, 64'(samp_resp), 64'(er));
      chk({nm, "_data"}, 64'(samp_data), 64'(ed));
      cycle();
      chk({nm, "_resp_one_cycle"}, 64'(samp_resp), 64'd0);
   endtask

   task automatic chk_order(input string nm, input int exp[$]);
      chk({nm, "_count"}, 64'(order.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < order.size(); i++)
         chk($sformatf("%s[%0d]", nm, i), 64'(order[i]), 64'(exp[i]));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reg_vec_t rt[11];
      int c0;
      rt[0]  = '{0, 14'h0,  32'h0,        1, 32'h0000_0104};
      rt[1]  = '{0, 14'h4,  32'h0,        1, 32'h0};
      rt[2]  = '{0, 14'h8,  32'h0,        1, 32'h0};
      rt[3]  = '{0, 14'hC,  32'h0,        1, 32'h0};
      rt[4]  = '{1, 14'h0,  32'hFFFF_0203, 0, 32'h0};
      rt[5]  = '{0, 14'h0,  32'h0,        1, 32'h0000_0203};
      rt[6]  = '{0, 14'h10, 32'h0,        0, 32'h0000_0203};
      rt[7]  = '{1, 14'h4,  32'h0000_1234, 0, 32'h0};
      rt[8]  = '{0, 14'h4,  32'h0,        1, 32'h0};
      rt[9]  = '{1, 14'h0,  32'h0000_0104, 0, 32'h0};
      rt[10] = '{0, 14'h0,  32'h0,        1, 32'h0000_0104};

      // reset state with both inputs idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_s0_tready", 64'(s0_tready), 64'd0);
      chk("rst_s1_tready", 64'(s1_tready), 64'd0);
      chk("rst_rd_resp", 64'(reg_rd_resp), 64'd0);
      chk("rst_rd_data", 64'(reg_rd_data), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      cycle();
      chk("idle_m_tvalid", 64'(m_tvalid), 64'd0);

      for (int i = 0; i < 11; i++) begin
         if (rt[i].wr) reg_write(rt[i].addr, rt[i].wdata);
         else reg_read($sformatf("regvec%0d", i), rt[i].addr, rt[i].resp, rt[i].rdata);
      end

      // weighted 4/1 with both ports continuously offering 3-beat packets
      order.delete(); first_fire = -1;
      for (int i = 0; i < 8; i++) send_pkt(0, 3);
      for (int i = 0; i < 2; i++) send_pkt(1, 3);
      cycle(); c0 = cyc;
      run(500, "wrr41");
      chk_order("wrr41_order", '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1});
      chk("wrr41_first_beat_cycle", 64'(first_fire), 64'(c0 + 2));
      chk("wrr41_span_one_bubble", 64'(last_fire - first_fire + 1), 64'd39);
      reg_read("cnt0_after_wrr", 14'h4, 1'b1, 32'd8);
      reg_read("cnt1_after_wrr", 14'h8, 1'b1, 32'd2);

      // only s1 active
      order.delete(); first_fire = -1;
      for (int i = 0; i < 5; i++) send_pkt(1, 2);
      cycle(); c0 = cyc;
      run(300, "s1only");
      chk_order("s1only_order", '{1, 1, 1, 1, 1});
      chk("s1only_first_beat_cycle", 64'(first_fire), 64'(c0 + 2));
      chk("s1only_span", 64'(last_fire - first_fire + 1), 64'd14);
      reg_read("cnt1_after_s1only", 14'h8, 1'b1, 32'd7);

      // backpressure and s0 valid gaps with s1 competing
      order.delete();
      rdy_rand = 1; gap_en = 1;
      for (int i = 0; i < 3; i++) begin send_pkt(0, 5); send_pkt(1, 2); end
      run(3000, "bp");
      rdy_rand = 0; gap_en = 0;
      cycle();
      chk("bp_pkts_done", 64'(order.size()), 64'd6);

      // zero weights give strict alternation
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1;
      reg_write(14'h0, 32'h0);
      order.delete();
      for (int i = 0; i < 3; i++) begin send_pkt(0, 2); send_pkt(1, 2); end
      run(300, "alt");
      chk_order("alt_order", '{0, 1, 0, 1, 0, 1});
      reg_read("cnt0_after_alt", 14'h4, 1'b1, 32'd3);

      // CNT_CLR on the same edge as a tlast handshake
      first_fire = -1;
      send_pkt(0, 1);
      cycle(); c0 = cyc;
      cycle();
      reg_wr_req = 1'b1; reg_wr_addr = 14'hC; reg_wr_data = 32'h1;
      cycle();
      reg_wr_req = 1'b0;
      chk("clr_collide_fire_cycle", 64'(first_fire), 64'(c0 + 2));
      run(50, "clr");
      reg_read("cnt0_after_clr", 14'h4, 1'b1, 32'd0);
      reg_read("cnt1_after_clr", 14'h8, 1'b1, 32'd0);

      // reset mid-packet
      send_pkt(1, 2);
      run(50, "pre_rst");
      send_pkt(0, 4);
      repeat (3) cycle();
      @(negedge clk);
      chk("midpkt_beat2_valid", 64'(m_tvalid), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("midpkt_rst_m_tvalid_async", 64'(m_tvalid), 64'd0);
      chk("midpkt_rst_s0_tready", 64'(s0_tready), 64'd0);
      src0.delete(); exp0.delete();
      in_pkt = 0; f0 = 1'b0; f1 = 1'b0; sv0 = 1'b0;
      @(posedge clk); #1;
      repeat (2) cycle();
      reset_n = 1'b1;
      reg_read("cnt0_after_rst", 14'h4, 1'b1, 32'd0);
      reg_read("cnt1_after_rst", 14'h8, 1'b1, 32'd0);
      reg_read("weight_after_rst", 14'h0, 1'b1, 32'h0000_0104);
      order.delete();
      send_pkt(0, 2); send_pkt(1, 2);
      run(100, "post_rst");
      chk_order("post_rst_order", '{0, 1});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
